pipe_reg_elastic: RTL and testbench
===================================

// Module: pipe_reg_elastic
// PURPOSE
//  Parametrised, elastic pipeline register chain. It generalises the fixed MEM/WB latch to
//  WIDTH-bit payloads and DEPTH stages, with a valid/ready handshake, back-pressure, flush
//  and a per-stage valid bit. It sits between any two CPU pipeline stages (IF/ID … MEM/WB).
//  The caller packs control and data fields into in_data_i.
// PARAMETERS
//  WIDTH  71  payload bits per stage; 71 = RegWrite+MemtoReg+read_data+ALU_result+rd
//  DEPTH  1   number of register stages; legal range 1..16; elaboration error otherwise
// PORTS
//  clk_i        in   1               clock; all flops update on its rising edge
//  rst_i        in   1               asynchronous reset, active-high
//  start_i      in   1               global enable; 0 freezes the whole chain
//  flush_i      in   1               synchronous kill of every stage
//  in_valid_i   in   1               upstream offers in_data_i
//  in_ready_o   out  1               chain accepts this cycle
//  in_data_i    in   WIDTH           upstream payload
//  out_valid_o  out  1               last stage holds a deliverable payload
//  out_ready_i  in   1               downstream accepts
//  out_data_o   out  WIDTH           data_q[DEPTH-1]
//  occupancy_o  out  $clog2(DEPTH+1) number of stages with valid_q=1 (combinational popcount)
// BEHAVIOUR
//  - State per stage k (0 = input side, DEPTH-1 = output side):
//    - valid_q[k]: 1 bit.
//    - data_q[k]: WIDTH bits.
//  - Reset (async, while rst_i=1):
//    - Every valid_q and data_q is cleared to 0.
//    - out_valid_o=0, out_data_o=0, occupancy_o=0.
//    - in_ready_o = start_i & ~flush_i.
//  - Advance enables (combinational, rippling from the output side):
//    - en[DEPTH-1] = start_i & ~flush_i & (~valid_q[DEPTH-1] | out_ready_i).
//    - en[k] = start_i & ~flush_i & (~valid_q[k] | en[k+1]).
//    - in_ready_o = en[0].
//    - out_valid_o = valid_q[DEPTH-1] & start_i & ~flush_i.
//  - Load: when en[k]=1, stage k copies stage k-1 (stage 0 copies in_valid_i / in_data_i).
//    When en[k]=0 the stage holds.
//  - Handshakes:
//    - Input transfer  = in_valid_i & in_ready_o.
//    - Output transfer = out_valid_o & out_ready_i.
//    - in_valid_i may be asserted regardless of in_ready_o.
//    - Payloads are never duplicated, dropped (except on flush) or reordered.
//  - Latency / throughput: DEPTH cycles from input transfer to out_valid_o with no stalls;
//    1 payload/cycle sustained.
//  - Full with out_ready_i=0: every en=0, in_ready_o=0, all stages hold.
//  - Full with out_ready_i=1: all stages shift, so a simultaneous accept and deliver occurs.
//    A bubble anywhere in the chain compresses as upstream stages advance into it.
//  - flush_i=1 (priority over start_i and the handshakes):
//    - Next edge clears every valid_q. Data is held; with the macro below, data is zeroed.
//    - Same cycle: in_ready_o=0 and out_valid_o=0, so neither a transfer in nor out occurs.
//  - start_i=0: no stage loads, in_ready_o=0, out_valid_o=0. Flush still applies.
//  - Reset asserted mid-stream: contents are discarded immediately; no partial outputs.
// CONFIGURATION
//  - PIPE_REG_ZERO_BUBBLE_EN defined:
//    - Whenever a stage loads valid=0, or is flushed, its data_q is written to 0.
//    - Bubbles therefore carry RegWrite=0, and out_data_o is 0 whenever valid_q[DEPTH-1]=0.
//  - Not defined: data_q loads the upstream value regardless of valid.
//    Payload bits of invalid stages are don't-care (no reset-free assumption on reset values).
// TESTING
//  - Reset, then DEPTH=3, in_valid_i=1, data 1,2,3…, out_ready_i=1:
//    out_valid_o rises on cycle 3; outputs 1,2,3 on consecutive cycles; occupancy_o=3 steady.
//  - Fill DEPTH=3 with A,B,C while holding out_ready_i=0:
//    in_ready_o=0 and occupancy_o=3; out_data_o=A holds.
//    Raising out_ready_i drains A,B,C in order.
//  - Insert a single bubble between A and B with out_ready_i=0, then release:
//    the bubble collapses; exactly A then B are output, with no duplicate.
//  - Full pipe plus flush_i pulse for one cycle with in_valid_i=1 and out_ready_i=1:
//    no transfer that cycle; occupancy_o=0 the next cycle; the following payload exits after DEPTH cycles.
//  - start_i=0 for 4 cycles mid-stream: no output transfer, contents unchanged, resumes in order.
//  - Macro defined, DEPTH=2, one valid payload 0x7F..F followed by bubbles:
//    out_data_o=0 once valid_q[1]=0.
//    Repeat with the macro undefined: out_valid_o sequence is identical.

Source files
------------

// File: rtl/pipe_reg_elastic.sv
// Elastic valid/ready pipeline register chain: DEPTH stages of WIDTH bits with flush and global enable.
// Optional macro PIPE_REG_ZERO_BUBBLE_EN zeroes the payload of every bubble and flushed stage.
module pipe_reg_elastic #(
    parameter int WIDTH = 71,
    parameter int DEPTH = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [WIDTH-1:0]             in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [WIDTH-1:0]             out_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 16) begin : g_depth_check
        $error("pipe_reg_elastic: DEPTH must be in 1..16");
    end

    logic                 run;
    logic [DEPTH-1:0]     en;
    logic [DEPTH-1:0]     stage_valid;
    logic [WIDTH-1:0]     stage_data [DEPTH];

    assign run = start_i & ~flush_i;

    // Enables ripple from the output side: a stage may load if it is empty or its successor moves.
    always_comb begin : enable_chain
        logic downstream;
        downstream = out_ready_i;
        en         = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            en[k]      = run & (~stage_valid[k] | downstream);
            downstream = en[k];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             src_v;
        logic [WIDTH-1:0] src_d;
        logic             valid_q, valid_d;
        logic [WIDTH-1:0] data_q, data_d;

        if (k == 0) begin : g_src_in
            assign src_v = in_valid_i;
            assign src_d = in_data_i;
        end else begin : g_src_prev
            assign src_v = stage_valid[k-1];
            assign src_d = stage_data[k-1];
        end

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (flush_i) begin
                valid_d = 1'b0;
`ifdef PIPE_REG_ZERO_BUBBLE_EN
                data_d  = '0;
`endif
            end else if (en[k]) begin
                valid_d = src_v;
`ifdef PIPE_REG_ZERO_BUBBLE_EN
                data_d  = src_v ? src_d : '0;
`else
                data_d  = src_d;
`endif
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign stage_valid[k] = valid_q;
        assign stage_data[k]  = data_q;
    end

    always_comb begin
        occupancy_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy_o = occupancy_o + OCC_W'(stage_valid[k]);
        end
    end

    assign in_ready_o  = en[0];
    assign out_valid_o = stage_valid[DEPTH-1] & run;
    assign out_data_o  = stage_data[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Scoreboard bench for pipe_reg_elastic at DEPTH=3: latency, back-pressure, bubbles, flush, stall, reset.
module tb_pipe_reg_elastic;

    localparam int WIDTH = 71;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occ;

    logic [WIDTH-1:0] sb[$];
    int               n_cmp = 0;
    int               n_err = 0;
    int               n_out = 0;

    always #5 clk = ~clk;

    pipe_reg_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .occupancy_o (occ)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at the negedge: records this cycle's transfers, then advances past the next posedge.
    task automatic finish_cycle();
        logic [WIDTH-1:0] exp;
        if (out_valid && out_ready) begin
            n_out++;
            check("sb_has_entry", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("out_data", 128'(out_data), 128'(exp));
            end
        end
        if (in_valid && in_ready) sb.push_back(in_data);
        if (flush) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && sb.size() != 0; i++) begin
            @(negedge clk);
            finish_cycle();
        end
        check("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    task automatic stream(input int n, input logic [WIDTH-1:0] base);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + WIDTH'(i);
            @(negedge clk);
            finish_cycle();
        end
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        logic [WIDTH-1:0] ones;
        int               n0;
        ones      = '1;
        rst       = 1'b1;
        start     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // reset state
        #2;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_occ",       128'(occ),       128'(0));
        check("rst_out_data",  128'(out_data),  128'(0));
        check("rst_in_ready",  128'(in_ready),  128'(1));
        start = 1'b0;
        #1;
        check("rst_in_ready_nostart", 128'(in_ready), 128'(0));
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // streaming latency and steady occupancy
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(i + 1);
            @(negedge clk);
            check("lat_out_valid", 128'(out_valid), 128'(i >= 3));
            check("lat_occ", 128'(occ), 128'((i >= 3) ? 3 : i));
            finish_cycle();
        end
        drain();

        // fill with back-pressure, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(32'hA0 + i);
            @(negedge clk);
            check("fill_in_ready", 128'(in_ready), 128'(1));
            finish_cycle();
        end
        in_data = WIDTH'(32'hD0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("full_in_ready",  128'(in_ready),  128'(0));
            check("full_occ",       128'(occ),       128'(3));
            check("full_out_valid", 128'(out_valid), 128'(1));
            check("full_out_data",  128'(out_data),  128'(32'hA0));
            finish_cycle();
        end
        drain();

        // single bubble between A and B under back-pressure
        n0        = n_out;
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = WIDTH'(32'hAA);
        @(negedge clk); finish_cycle();
        in_valid  = 1'b0;
        @(negedge clk); finish_cycle();
        in_valid  = 1'b1; in_data = WIDTH'(32'hBB);
        @(negedge clk); finish_cycle();
        in_valid  = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check("bubble_occ",      128'(occ),      128'(2));
            check("bubble_out_data", 128'(out_data), 128'(32'hAA));
            finish_cycle();
        end
        drain();
        check("bubble_out_count", 128'(n_out - n0), 128'(2));

        // flush of a full, streaming pipe
        stream(5, WIDTH'(32'h100));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = WIDTH'(32'h1FF);
        @(negedge clk);
        check("flush_in_ready",  128'(in_ready),  128'(0));
        check("flush_out_valid", 128'(out_valid), 128'(0));
        finish_cycle();
        flush   = 1'b0;
        in_data = WIDTH'(32'h200);
        @(negedge clk);
        check("post_flush_occ",       128'(occ),       128'(0));
        check("post_flush_out_valid", 128'(out_valid), 128'(0));
        finish_cycle();
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("post_flush_lat", 128'(out_valid), 128'(i == 3));
            finish_cycle();
        end
        drain();

        // start_i low for 4 cycles mid-stream
        stream(5, WIDTH'(32'h300));
        start   = 1'b0;
        in_data = WIDTH'(32'h305);
        held    = '0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("stall_in_ready",  128'(in_ready),  128'(0));
            check("stall_out_valid", 128'(out_valid), 128'(0));
            check("stall_occ",       128'(occ),       128'(3));
            if (j == 0) held = out_data;
            else check("stall_out_data", 128'(out_data), 128'(held));
            finish_cycle();
        end
        start = 1'b1;
        stream(3, WIDTH'(32'h305));
        drain();

        // reset asserted mid-stream
        stream(4, WIDTH'(32'h400));
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_occ",       128'(occ),       128'(0));
        check("midrst_out_data",  128'(out_data),  128'(0));
        @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;

        // one all-ones payload followed by bubbles
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = ones;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ones_out_valid", 128'(out_valid), 128'(i == 3));
`ifdef PIPE_REG_ZERO_BUBBLE_EN
            if (i >= 4) check("bubble_zero", 128'(out_data), 128'(0));
`endif
            finish_cycle();
            in_valid = 1'b0;
            in_data  = '0;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
